// File: rtl/challenge_descrambler_pkg.sv
// Shared definitions for the challenge scrambler/descrambler pair: word width,
// feedback taps, FSM states and the tap feedback function.
package challenge_descrambler_pkg;
  localparam int CHAL_W = 8;
  localparam logic [CHAL_W-1:0] DEFAULT_FB_TAPS = 8'hB8;

  typedef enum logic {SEED, RUN} state_t;

  // XNOR over the tapped history bits; masked-off zeros do not change parity
  function automatic logic fb_xnor(input logic [CHAL_W-1:0] hist,
                                   input logic [CHAL_W-1:0] taps);
    return ~^(hist & taps);
  endfunction
endpackage

// File: rtl/descramble_step.sv
// One descrambling step: undo the history mask and compute the next feedback bit.
module descramble_step
  import challenge_descrambler_pkg::*;
#(
  parameter logic [CHAL_W-1:0] FB_TAPS = DEFAULT_FB_TAPS
) (
  input  logic [CHAL_W-1:0] prev,
  input  logic              fb,
  input  logic [CHAL_W-1:0] in_data,
  output logic [CHAL_W-1:0] recovered,
  output logic              fb_next
);
  assign recovered = in_data ^ {prev[CHAL_W-2:0], fb};
  assign fb_next   = fb_xnor(prev, FB_TAPS);
endmodule

// File: rtl/challenge_descrambler.sv
// Self-synchronising challenge descrambler with a one-word output buffer,
// seed/run FSM and saturating accepted-word counter.
module challenge_descrambler
  import challenge_descrambler_pkg::*;
#(
  parameter logic [CHAL_W-1:0] FB_TAPS = DEFAULT_FB_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAL_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAL_W-1:0] out_data,
  output logic [7:0]        word_count,
  output logic              seeded
);
  state_t            state;
  logic [CHAL_W-1:0] prev;
  logic              fb;
  logic [CHAL_W-1:0] recovered;
  logic              fb_next;
  logic              in_xfer;
  logic              out_xfer;

  descramble_step #(.FB_TAPS(FB_TAPS)) u_step (
    .prev      (prev),
    .fb        (fb),
    .in_data   (in_data),
    .recovered (recovered),
    .fb_next   (fb_next)
  );

  // Buffer can take a word when empty or being drained this same cycle
  assign in_ready = !sync_clear && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign seeded   = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEED;
      out_valid  <= 1'b0;
      out_data   <= '0;
      prev       <= '0;
      fb         <= 1'b0;
      word_count <= '0;
    end else if (sync_clear) begin
      state      <= SEED;
      out_valid  <= 1'b0;
      prev       <= '0;
      fb         <= 1'b0;
      word_count <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      prev      <= in_data;
      if (state == SEED) begin
        // Seed word passes through unchanged and primes the history
        out_data   <= in_data;
        fb         <= 1'b0;
        word_count <= 8'd1;
        state      <= RUN;
      end else begin
        out_data   <= recovered;
        fb         <= fb_next;
        word_count <= (word_count == 8'hFF) ? 8'hFF : word_count + 8'd1;
      end
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_challenge_descrambler.sv
// Directed-vector and scrambler-loopback bench for challenge_descrambler.
module tb_challenge_descrambler;
  logic       clk = 1'b0;
  logic       rst;
  logic       sync_clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] word_count;
  logic       seeded;

  int n_vec = 0;
  int n_bad = 0;

  challenge_descrambler dut (
    .clk        (clk),
    .rst        (rst),
    .sync_clear (sync_clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count),
    .seeded     (seeded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] din;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [7:0] e_wc;
    logic       e_sd;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic [7:0] expq[$];
  logic [7:0] orig, scr, sprev, exp_w, od_s;
  logic       sfb, first, ixf, oxf;
  int         sent, got;
  localparam int N = 200;

  initial begin
    rst = 1'b1; sync_clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    chk("rst in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst out_data", out_data, 8'h00);
    chk("rst word_count", word_count, 8'h00);
    chk("rst seeded", {7'd0, seeded}, 8'd0);
    @(negedge clk); rst = 1'b0;

    //         clr vld din    ordy ir ov od     wc     sd
    vt[0]  = '{0, 1, 8'h00, 1,   1, 1, 8'h00, 8'd1, 1};
    vt[1]  = '{0, 1, 8'h00, 1,   1, 1, 8'h00, 8'd2, 1};
    vt[2]  = '{0, 1, 8'h01, 1,   1, 1, 8'h00, 8'd3, 1};
    vt[3]  = '{1, 1, 8'h55, 1,   0, 0, 8'h00, 8'd0, 0};
    vt[4]  = '{0, 1, 8'hA5, 1,   1, 1, 8'hA5, 8'd1, 1};
    vt[5]  = '{0, 1, 8'h4B, 1,   1, 1, 8'h01, 8'd2, 1};
    vt[6]  = '{0, 1, 8'h33, 0,   0, 1, 8'h01, 8'd2, 1};
    vt[7]  = '{0, 1, 8'h33, 0,   0, 1, 8'h01, 8'd2, 1};
    vt[8]  = '{0, 1, 8'h33, 1,   1, 1, 8'hA4, 8'd3, 1};
    vt[9]  = '{0, 0, 8'h00, 1,   1, 0, 8'hA4, 8'd3, 1};
    vt[10] = '{0, 0, 8'h00, 0,   1, 0, 8'hA4, 8'd3, 1};
    vt[11] = '{0, 1, 8'h10, 0,   1, 1, 8'h76, 8'd4, 1};
    vt[12] = '{0, 0, 8'h00, 0,   0, 1, 8'h76, 8'd4, 1};
    vt[13] = '{0, 0, 8'h00, 1,   1, 0, 8'h76, 8'd4, 1};
    vt[14] = '{1, 0, 8'h00, 1,   0, 0, 8'h76, 8'd0, 0};
    vt[15] = '{0, 1, 8'h4B, 1,   1, 1, 8'h4B, 8'd1, 1};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sync_clear = vt[i].clr; in_valid = vt[i].vld; in_data = vt[i].din; out_ready = vt[i].ordy;
      #1 chk($sformatf("v%0d in_ready", i), {7'd0, in_ready}, {7'd0, vt[i].e_ir});
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), {7'd0, out_valid}, {7'd0, vt[i].e_ov});
      chk($sformatf("v%0d out_data", i), out_data, vt[i].e_od);
      chk($sformatf("v%0d word_count", i), word_count, vt[i].e_wc);
      chk($sformatf("v%0d seeded", i), {7'd0, seeded}, {7'd0, vt[i].e_sd});
    end

    // Asynchronous reset mid-stream drops the buffered word
    @(negedge clk);
    sync_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", {7'd0, out_valid}, 8'd0);
    chk("midrst out_data", out_data, 8'h00);
    chk("midrst word_count", word_count, 8'h00);
    chk("midrst seeded", {7'd0, seeded}, 8'd0);
    chk("midrst in_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk); rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("postrst seed", out_data, 8'h77);
    chk("postrst count", word_count, 8'd1);
    @(negedge clk); in_data = 8'h78;
    @(posedge clk); #1;
    chk("postrst run", out_data, 8'h96);

    // Saturation of the accepted-word counter
    @(negedge clk); sync_clear = 1'b1; in_valid = 1'b0;
    @(negedge clk); sync_clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      in_data = k[7:0];
      @(posedge clk); #1;
      if (k == 254) chk("sat 254", word_count, 8'hFE);
      if (k == 255) chk("sat 255", word_count, 8'hFF);
      if (k == 300) chk("sat 300", word_count, 8'hFF);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Loopback: bench scrambler feeds the DUT with random handshakes
    sync_clear = 1'b1;
    @(negedge clk); sync_clear = 1'b0;
    first = 1'b1; sprev = '0; sfb = 1'b0; sent = 0; got = 0;
    orig = 8'($urandom); scr = orig;
    for (int cyc = 0; cyc < 4000 && got < N; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
      in_data   = scr;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      ixf = in_valid && in_ready;
      oxf = out_valid && out_ready;
      od_s = out_data;
      @(posedge clk);
      if (oxf) begin
        if (expq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rand unexpected word: got %h want none", od_s);
        end else begin
          exp_w = expq.pop_front();
          chk($sformatf("rand word %0d", got), od_s, exp_w);
        end
        got++;
      end
      if (ixf) begin
        expq.push_back(orig);
        sfb   = first ? 1'b0 : ~^(sprev & 8'hB8);
        sprev = scr;
        first = 1'b0;
        sent++;
        orig = 8'($urandom);
        scr  = orig ^ {sprev[6:0], sfb};
      end
    end
    n_vec++;
    if (got != N) begin
      n_bad++;
      $display("FAIL rand count: got %0d words want %0d", got, N);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
